tag_stream_src: RTL and testbench

Buffers timestamp records produced by the tagger core and serialises them, one byte at a time, onto one source port of the host output multiplexer. The multiplexer's register-manager port outranks this block, so replies keep flowing while the stream runs. The block sits between the tagger core, upstream, and one `omux_*` source slot of `host_iface`, downstream. It drops records when its FIFO is full and counts the drops, so stream loss is visible over the register interface.

---
 rtl/tag_stream_src_if.sv | 20 ++
 rtl/tag_stream_src.sv | 137 +++++++++++++
 tb/tb_tag_stream_src.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tag_stream_src_if.sv
// Byte-wide source slot of the host output multiplexer: request, select and data.
// No storage or latency; the mux consumes a byte in any cycle where select and request are both high.
// Back-pressure is the mux holding select low; the source keeps its byte and request stable meanwhile.
interface tag_stream_src_if;
    logic       omux_req_o;
    logic       omux_sel_i;
    logic [7:0] omux_data_o;

    modport master (
        output omux_req_o,
        output omux_data_o,
        input  omux_sel_i
    );

    modport slave (
        input  omux_req_o,
        input  omux_data_o,
        output omux_sel_i
    );
endinterface

// File: rtl/tag_stream_src.sv
// Buffers tagger timestamp records in a FIFO and streams them MSB-first, one byte per consume, to a mux slot.
// Latency: record strobed at edge N is counted at N, loaded into the holding register at N+1, requested after N+1.
// No back-pressure upstream: records arriving while the FIFO is full are dropped and counted (saturating).
module tag_stream_src #(
    parameter int RECORD_BYTES = 6,
    parameter int DEPTH        = 16,
    parameter int MAX_BURST    = 8
) (
    input  logic                          clk_i,
    input  logic                          nreset_i,
    input  logic                          en_i,
    input  logic [8*RECORD_BYTES-1:0]     rec_i,
    input  logic                          rec_valid_i,
    tag_stream_src_if.master              omux,
    output logic [$clog2(DEPTH):0]        fifo_level_o,
    output logic [15:0]                   lost_count_o,
    input  logic                          lost_clr_i
);

    localparam int W  = 8 * RECORD_BYTES;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = (RECORD_BYTES > 1) ? $clog2(RECORD_BYTES) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [BW-1:0] BIDX_LAST  = BW'(RECORD_BYTES - 1);
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic [W-1:0]  r_hold;
    logic          r_hold_valid;
    logic [BW-1:0] r_bidx;
    logic [CW-1:0] r_burst;
    logic          r_gap;
    logic [15:0]   r_lost;

    logic          w_req;
    logic          w_consume;
    logic          w_last;
    logic          w_wr;
    logic          w_drop;
    logic          w_pop;
    logic [7:0]    w_byte;

    // Level is the registered value: a pop in this cycle never frees a slot for this cycle's write.
    assign w_wr      = rec_valid_i && en_i && (r_level != LEVEL_FULL);
    assign w_drop    = rec_valid_i && en_i && (r_level == LEVEL_FULL);
    assign w_req     = r_hold_valid && !r_gap;
    assign w_consume = w_req && omux.omux_sel_i;
    assign w_last    = w_consume && (r_bidx == BIDX_LAST);
    assign w_pop     = (r_level != '0) && (!r_hold_valid || w_last);

    always_comb begin
        w_byte = '0;
        for (int i = 0; i < RECORD_BYTES; i++) begin
            if (r_bidx == BW'(RECORD_BYTES - 1 - i)) begin
                w_byte = r_hold[i*8 +: 8];
            end
        end
    end

    assign omux.omux_req_o  = w_req;
    assign omux.omux_data_o = w_byte;
    assign fifo_level_o     = r_level;
    assign lost_count_o     = r_lost;

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wptr] <= rec_i;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_level      <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_bidx       <= '0;
            r_burst      <= '0;
            r_gap        <= 1'b0;
            r_lost       <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end

            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase

            if (w_pop) begin
                r_hold       <= r_mem[r_rptr];
                r_hold_valid <= 1'b1;
            end else if (w_last) begin
                r_hold_valid <= 1'b0;
            end

            if (w_pop || w_last) begin
                r_bidx <= '0;
            end else if (w_consume) begin
                r_bidx <= r_bidx + BW'(1);
            end

            // A one-cycle request drop every MAX_BURST records lets the mux re-arbitrate.
            r_gap <= w_last && (r_burst == BURST_LAST);
            if (w_last) begin
                if (!w_pop || (r_burst == BURST_LAST)) begin
                    r_burst <= '0;
                end else begin
                    r_burst <= r_burst + CW'(1);
                end
            end

            if (w_drop) begin
                if (lost_clr_i) begin
                    r_lost <= 16'd1;
                end else if (r_lost != 16'hFFFF) begin
                    r_lost <= r_lost + 16'd1;
                end
            end else if (lost_clr_i) begin
                r_lost <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tag_stream_src.sv
// Self-checking bench for tag_stream_src: directed scenarios plus a randomized run against a queue-based model.
module tb_tag_stream_src;

    localparam int RB    = 6;
    localparam int DEPTH = 16;
    localparam int MB    = 8;
    localparam int W     = 8 * RB;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk       = 1'b0;
    logic          nreset    = 1'b0;
    logic          en        = 1'b0;
    logic [W-1:0]  rec       = '0;
    logic          rec_valid = 1'b0;
    logic          lost_clr  = 1'b0;
    logic [LW-1:0] level;
    logic [15:0]   lost;

    int checks = 0;
    int errors = 0;

    tag_stream_src_if omux ();

    tag_stream_src #(
        .RECORD_BYTES (RB),
        .DEPTH        (DEPTH),
        .MAX_BURST    (MB)
    ) dut (
        .clk_i        (clk),
        .nreset_i     (nreset),
        .en_i         (en),
        .rec_i        (rec),
        .rec_valid_i  (rec_valid),
        .omux         (omux),
        .fifo_level_o (level),
        .lost_count_o (lost),
        .lost_clr_i   (lost_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] rec_byte(input logic [W-1:0] r, input int k);
        return r[(RB-1-k)*8 +: 8];
    endfunction

    function automatic logic [W-1:0] rand_rec();
        return {16'($urandom), 32'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en        = 1'b0;
        rec_valid = 1'b0;
        lost_clr  = 1'b0;
        omux.omux_sel_i = 1'b0;
        nreset    = 1'b0;
        repeat (2) tick();
        nreset    = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        omux.omux_sel_i = 1'b0;
        nreset = 1'b0;
        tick();
        checks++;
        if (omux.omux_req_o !== 1'b0) begin
            errors++; $display("FAIL reset_req: got %b expected 0", omux.omux_req_o);
        end
        checks++;
        if (level !== '0) begin
            errors++; $display("FAIL reset_level: got %0d expected 0", level);
        end
        checks++;
        if (lost !== 16'd0) begin
            errors++; $display("FAIL reset_lost: got %0d expected 0", lost);
        end
    endtask

    task automatic test_single_record();
        logic [7:0] exp_b [RB];
        exp_b = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
        do_reset();
        en = 1'b1;
        rec = 48'h0A0B0C0D0E0F;
        rec_valid = 1'b1;
        tick();
        rec_valid = 1'b0;
        checks++;
        if (level !== LW'(1) || omux.omux_req_o !== 1'b0) begin
            errors++; $display("FAIL single_strobe: level %0d req %b, expected level 1 req 0", level, omux.omux_req_o);
        end
        tick();
        checks++;
        if (level !== '0 || omux.omux_req_o !== 1'b1) begin
            errors++; $display("FAIL single_load: level %0d req %b, expected level 0 req 1", level, omux.omux_req_o);
        end
        omux.omux_sel_i = 1'b1;
        for (int i = 0; i < RB; i++) begin
            checks++;
            if (omux.omux_req_o !== 1'b1 || omux.omux_data_o !== exp_b[i]) begin
                errors++; $display("FAIL single_byte%0d: req %b data %h, expected req 1 data %h", i, omux.omux_req_o, omux.omux_data_o, exp_b[i]);
            end
            tick();
        end
        omux.omux_sel_i = 1'b0;
        checks++;
        if (omux.omux_req_o !== 1'b0 || level !== '0) begin
            errors++; $display("FAIL single_done: req %b level %0d, expected req 0 level 0", omux.omux_req_o, level);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] sent_q [$];
        logic [W-1:0] r;
        int n;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            r = rand_rec();
            rec = r;
            rec_valid = 1'b1;
            if (i < DEPTH + 1) sent_q.push_back(r);
            tick();
        end
        rec_valid = 1'b0;
        checks++;
        if (level !== LW'(DEPTH)) begin
            errors++; $display("FAIL overflow_level: got %0d expected %0d", level, DEPTH);
        end
        checks++;
        if (lost !== 16'd3) begin
            errors++; $display("FAIL overflow_lost: got %0d expected 3", lost);
        end
        n = 0;
        omux.omux_sel_i = 1'b1;
        for (int c = 0; c < 400 && n < (DEPTH + 1) * RB; c++) begin
            if (omux.omux_req_o) begin
                checks++;
                if (omux.omux_data_o !== rec_byte(sent_q[n / RB], n % RB)) begin
                    errors++; $display("FAIL overflow_byte%0d: got %h expected %h", n, omux.omux_data_o, rec_byte(sent_q[n / RB], n % RB));
                end
                n++;
            end
            tick();
        end
        omux.omux_sel_i = 1'b0;
        checks++;
        if (n !== (DEPTH + 1) * RB || omux.omux_req_o !== 1'b0 || level !== '0) begin
            errors++; $display("FAIL overflow_drain: bytes %0d req %b level %0d, expected bytes %0d req 0 level 0", n, omux.omux_req_o, level, (DEPTH + 1) * RB);
        end
        lost_clr = 1'b1;
        tick();
        lost_clr = 1'b0;
        checks++;
        if (lost !== 16'd0) begin
            errors++; $display("FAIL overflow_clear: got %0d expected 0", lost);
        end
    endtask

    task automatic test_burst_gap();
        logic [W-1:0] sent_q [$];
        int n, gap_cycles, bad_low;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rec = rand_rec();
            sent_q.push_back(rec);
            rec_valid = 1'b1;
            tick();
        end
        rec_valid = 1'b0;
        n = 0; gap_cycles = 0; bad_low = 0;
        omux.omux_sel_i = 1'b1;
        for (int c = 0; c < 200 && n < 60; c++) begin
            if (omux.omux_req_o) begin
                checks++;
                if (omux.omux_data_o !== rec_byte(sent_q[n / RB], n % RB)) begin
                    errors++; $display("FAIL burst_byte%0d: got %h expected %h", n, omux.omux_data_o, rec_byte(sent_q[n / RB], n % RB));
                end
                n++;
            end else if (n == MB * RB) begin
                gap_cycles++;
            end else begin
                bad_low++;
            end
            tick();
        end
        omux.omux_sel_i = 1'b0;
        checks++;
        if (gap_cycles !== 1 || bad_low !== 0 || n !== 60) begin
            errors++; $display("FAIL burst_gap: gap cycles %0d other low %0d bytes %0d, expected 1, 0, 60", gap_cycles, bad_low, n);
        end
        checks++;
        if (omux.omux_req_o !== 1'b0) begin
            errors++; $display("FAIL burst_end_req: got %b expected 0", omux.omux_req_o);
        end
    endtask

    task automatic test_enable_gating();
        do_reset();
        en = 1'b0;
        omux.omux_sel_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rec = rand_rec();
            rec_valid = 1'b1;
            tick();
        end
        rec_valid = 1'b0;
        repeat (2) tick();
        omux.omux_sel_i = 1'b0;
        checks++;
        if (omux.omux_req_o !== 1'b0 || level !== '0 || lost !== 16'd0) begin
            errors++; $display("FAIL enable_gating: req %b level %0d lost %0d, expected 0 0 0", omux.omux_req_o, level, lost);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        en = 1'b1;
        rec_valid = 1'b1;
        repeat (DEPTH + 1 + 65540) tick();
        checks++;
        if (lost !== 16'hFFFF) begin
            errors++; $display("FAIL sat_lost: got %h expected ffff", lost);
        end
        lost_clr = 1'b1;
        tick();
        checks++;
        if (lost !== 16'd1) begin
            errors++; $display("FAIL sat_clear_with_drop: got %0d expected 1", lost);
        end
        rec_valid = 1'b0;
        tick();
        lost_clr = 1'b0;
        checks++;
        if (lost !== 16'd0) begin
            errors++; $display("FAIL sat_clear: got %0d expected 0", lost);
        end
    endtask

    task automatic test_reset_mid_record();
        logic [W-1:0] r;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rec = rand_rec();
            rec_valid = 1'b1;
            tick();
        end
        rec_valid = 1'b0;
        omux.omux_sel_i = 1'b1;
        repeat (3) tick();
        checks++;
        if (omux.omux_req_o !== 1'b1) begin
            errors++; $display("FAIL midrst_pre_req: got %b expected 1", omux.omux_req_o);
        end
        #2;
        nreset = 1'b0;
        #1;
        checks++;
        if (omux.omux_req_o !== 1'b0 || level !== '0) begin
            errors++; $display("FAIL midrst_async: req %b level %0d, expected 0 0", omux.omux_req_o, level);
        end
        tick();
        nreset = 1'b1;
        repeat (2) tick();
        checks++;
        if (omux.omux_req_o !== 1'b0 || level !== '0) begin
            errors++; $display("FAIL midrst_release: req %b level %0d, expected 0 0", omux.omux_req_o, level);
        end
        r = rand_rec();
        rec = r;
        rec_valid = 1'b1;
        tick();
        rec_valid = 1'b0;
        tick();
        checks++;
        if (omux.omux_req_o !== 1'b1 || omux.omux_data_o !== rec_byte(r, 0)) begin
            errors++; $display("FAIL midrst_restart: req %b data %h, expected 1 %h", omux.omux_req_o, omux.omux_data_o, rec_byte(r, 0));
        end
        omux.omux_sel_i = 1'b0;
    endtask

    // Reference: FIFO as a queue, the record on the wire with a sent-byte count, records per burst.
    task automatic test_random_stream();
        logic [W-1:0] fifo_q [$];
        logic [W-1:0] cur;
        bit  cur_v, gap, exp_req, cons, fin, take, accept, drop;
        int  sent, burst, lost_m;
        do_reset();
        cur = '0; cur_v = 0; gap = 0; sent = 0; burst = 0; lost_m = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            en        = ($urandom_range(0, 9) != 0);
            rec       = rand_rec();
            rec_valid = ($urandom_range(0, 9) < 4);
            lost_clr  = ($urandom_range(0, 49) == 0);
            omux.omux_sel_i = ((cyc / 400) % 2 == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);

            exp_req = cur_v && !gap;
            checks++;
            if (omux.omux_req_o !== exp_req) begin
                errors++; $display("FAIL rand_req@%0d: got %b expected %b", cyc, omux.omux_req_o, exp_req);
            end
            if (exp_req) begin
                checks++;
                if (omux.omux_data_o !== rec_byte(cur, sent)) begin
                    errors++; $display("FAIL rand_data@%0d: got %h expected %h", cyc, omux.omux_data_o, rec_byte(cur, sent));
                end
            end
            checks++;
            if (level !== LW'(fifo_q.size())) begin
                errors++; $display("FAIL rand_level@%0d: got %0d expected %0d", cyc, level, fifo_q.size());
            end
            checks++;
            if (lost !== 16'(lost_m)) begin
                errors++; $display("FAIL rand_lost@%0d: got %0d expected %0d", cyc, lost, lost_m);
            end

            cons   = exp_req && omux.omux_sel_i;
            fin    = cons && (sent == RB - 1);
            accept = rec_valid && en && (fifo_q.size() != DEPTH);
            drop   = rec_valid && en && (fifo_q.size() == DEPTH);
            take   = (fifo_q.size() > 0) && (!cur_v || fin);
            gap    = 0;
            if (cons) sent++;
            if (fin) begin
                sent = 0;
                burst++;
                if (burst == MB) begin
                    burst = 0;
                    gap = 1;
                end
            end
            if (take) begin
                cur = fifo_q.pop_front();
                cur_v = 1;
                sent = 0;
            end else if (fin) begin
                cur_v = 0;
                burst = 0;
            end
            if (accept) fifo_q.push_back(rec);
            if (drop) lost_m = lost_clr ? 1 : ((lost_m < 65535) ? lost_m + 1 : lost_m);
            else if (lost_clr) lost_m = 0;
            tick();
        end
        rec_valid = 1'b0;
        lost_clr  = 1'b0;
        omux.omux_sel_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_record();
        test_overflow();
        test_burst_gap();
        test_enable_gating();
        test_reset_mid_record();
        test_random_stream();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
